pifo_calendar_gpfc_ctrl: RTL and testbench



---
 rtl/pifo_gpfc_pkg.sv | 23 ++
 rtl/pifo_occupancy_counter.sv | 75 +++++++
 rtl/pifo_calendar_gpfc_ctrl.sv | 143 ++++++++++++++
 tb/tb_pifo_calendar_gpfc_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pifo_gpfc_pkg.sv
// Shared definitions for the PIFO calendar / GPFC controller: element layout
// and controller FSM state encoding.
package pifo_gpfc_pkg;

  localparam int ELEMENT_WIDTH = 40;

  localparam int VALID_BIT     = 39;
  localparam int OVERFLOW_BIT  = 38;
  localparam int PIFO_RANK_LSB = 21;
  localparam int PIFO_RANK_W   = 17;
  localparam int GPFC_COS_LSB  = 18;
  localparam int GPFC_COS_W    = 3;
  localparam int GPFC_RANK_LSB = 12;
  localparam int GPFC_RANK_W   = 6;
  localparam int ADDRESS_LSB   = 0;
  localparam int ADDRESS_W     = 12;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/pifo_occupancy_counter.sv
// Occupancy tracking and enqueue/dequeue fire decisions for the PIFO array.
// While flushing, a pop fires every cycle the array is non-empty.
module pifo_occupancy_counter
  import pifo_gpfc_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enq_valid,
  input  logic                 deq_req,
  input  logic                 flushing,
  output logic                 enq_fire,
  output logic                 deq_fire,
  output logic                 enq_ready,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 full,
  output logic                 empty
);

  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] ONE_C   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] ZERO_C  = CNT_WIDTH'(0);

  logic [CNT_WIDTH-1:0] count_r;
  logic                 full_s;
  logic                 empty_s;
  logic                 enq_ready_s;
  logic                 enq_fire_s;
  logic                 deq_fire_s;

  assign full_s  = (count_r == DEPTH_C);
  assign empty_s = (count_r == ZERO_C);

  // Fire decisions; a pop in the same cycle frees the slot an enqueue needs.
  always_comb begin
    deq_fire_s  = 1'b0;
    enq_ready_s = 1'b0;
    if (flushing) begin
      deq_fire_s  = ~empty_s;
      enq_ready_s = 1'b0;
    end else begin
      deq_fire_s  = deq_req & ~empty_s;
      enq_ready_s = ~full_s | deq_fire_s;
    end
    if (rst) begin
      enq_ready_s = 1'b0;
    end else begin
      enq_ready_s = enq_ready_s;
    end
    enq_fire_s = enq_valid & enq_ready_s;
  end

  // Occupancy register, updated at the fire edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= ZERO_C;
    end else if (enq_fire_s && !deq_fire_s) begin
      count_r <= count_r + ONE_C;
    end else if (!enq_fire_s && deq_fire_s) begin
      count_r <= count_r - ONE_C;
    end else begin
      count_r <= count_r;
    end
  end

  assign enq_fire  = enq_fire_s;
  assign deq_fire  = deq_fire_s;
  assign enq_ready = enq_ready_s;
  assign count     = count_r;
  assign full      = full_s;
  assign empty     = empty_s;

endmodule

// File: rtl/pifo_calendar_gpfc_ctrl.sv
// Controller for a PIFO calendar array with GPFC fields: registered insert/pop
// strobes, popped-element capture and a flush mode that drains the array.
module pifo_calendar_gpfc_ctrl
  import pifo_gpfc_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int ELEMENT_WIDTH = pifo_gpfc_pkg::ELEMENT_WIDTH,
  parameter int CNT_WIDTH     = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid,
  input  logic [ELEMENT_WIDTH-1:0] enq_data,
  output logic                     enq_ready,
  input  logic                     deq_req,
  output logic                     deq_valid,
  output logic [ELEMENT_WIDTH-1:0] deq_data,
  input  logic                     flush,
  input  logic [ELEMENT_WIDTH-1:0] head_element,
  output logic                     ctl_insert,
  output logic                     ctl_pop,
  output logic [ELEMENT_WIDTH-1:0] ctl_input,
  output logic                     global_overflow_bit,
  output logic [CNT_WIDTH-1:0]     count,
  output logic                     full,
  output logic                     empty,
  output logic                     busy
);

  localparam logic [ELEMENT_WIDTH-1:0] VALID_MASK_C = {1'b1, {(ELEMENT_WIDTH-1){1'b0}}};
  localparam logic [ELEMENT_WIDTH-1:0] ZERO_ELEM_C  = {ELEMENT_WIDTH{1'b0}};

  ctrl_state_e              state_r;
  ctrl_state_e              state_next_s;
  logic                     enq_fire_s;
  logic                     deq_fire_s;
  logic                     empty_s;
  logic                     ctl_insert_r;
  logic                     ctl_pop_r;
  logic                     pop_deliver_r;
  logic [ELEMENT_WIDTH-1:0] ctl_input_r;
  logic                     deq_valid_r;
  logic [ELEMENT_WIDTH-1:0] deq_data_r;
  logic                     global_overflow_r;

  pifo_occupancy_counter #(
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_occupancy (
    .clk       (clk),
    .rst       (rst),
    .enq_valid (enq_valid),
    .deq_req   (deq_req),
    .flushing  (state_r == ST_FLUSH),
    .enq_fire  (enq_fire_s),
    .deq_fire  (deq_fire_s),
    .enq_ready (enq_ready),
    .count     (count),
    .full      (full),
    .empty     (empty_s)
  );

  // Next state; leave FLUSH only once drained and the last pop has issued.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (flush) begin
          state_next_s = ST_FLUSH;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (empty_s && !ctl_pop_r) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_FLUSH;
        end
      end
      default: state_next_s = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Array strobes issue the cycle after the fire; flush pops are not delivered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_insert_r  <= 1'b0;
      ctl_pop_r     <= 1'b0;
      pop_deliver_r <= 1'b0;
      ctl_input_r   <= ZERO_ELEM_C;
    end else begin
      ctl_insert_r  <= enq_fire_s;
      ctl_pop_r     <= deq_fire_s;
      pop_deliver_r <= deq_fire_s & (state_r == ST_RUN);
      if (enq_fire_s) begin
        ctl_input_r <= enq_data | VALID_MASK_C;
      end else begin
        ctl_input_r <= ctl_input_r;
      end
    end
  end

  // Capture the head atom while the pop strobe is on the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deq_valid_r       <= 1'b0;
      deq_data_r        <= ZERO_ELEM_C;
      global_overflow_r <= 1'b0;
    end else begin
      deq_valid_r <= ctl_pop_r & pop_deliver_r;
      if (ctl_pop_r && pop_deliver_r) begin
        deq_data_r <= head_element;
      end else begin
        deq_data_r <= deq_data_r;
      end
      if (ctl_pop_r) begin
        global_overflow_r <= head_element[OVERFLOW_BIT];
      end else begin
        global_overflow_r <= global_overflow_r;
      end
    end
  end

  assign ctl_insert          = ctl_insert_r;
  assign ctl_pop             = ctl_pop_r;
  assign ctl_input           = ctl_input_r;
  assign deq_valid           = deq_valid_r;
  assign deq_data            = deq_data_r;
  assign global_overflow_bit = global_overflow_r;
  assign empty               = empty_s;
  assign busy                = (state_r == ST_FLUSH);

endmodule

// File: tb/tb_pifo_calendar_gpfc_ctrl.sv
// Directed bench for pifo_calendar_gpfc_ctrl with DEPTH=4 and a driven head atom.
module tb_pifo_calendar_gpfc_ctrl;

  localparam int DEPTH = 4;
  localparam int EW    = 40;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          enq_valid;
  logic [EW-1:0] enq_data;
  logic          enq_ready;
  logic          deq_req;
  logic          deq_valid;
  logic [EW-1:0] deq_data;
  logic          flush;
  logic [EW-1:0] head_element;
  logic          ctl_insert;
  logic          ctl_pop;
  logic [EW-1:0] ctl_input;
  logic          global_overflow_bit;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  pifo_calendar_gpfc_ctrl #(.DEPTH(DEPTH), .ELEMENT_WIDTH(EW), .CNT_WIDTH(CW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .enq_valid           (enq_valid),
    .enq_data            (enq_data),
    .enq_ready           (enq_ready),
    .deq_req             (deq_req),
    .deq_valid           (deq_valid),
    .deq_data            (deq_data),
    .flush               (flush),
    .head_element        (head_element),
    .ctl_insert          (ctl_insert),
    .ctl_pop             (ctl_pop),
    .ctl_input           (ctl_input),
    .global_overflow_bit (global_overflow_bit),
    .count               (count),
    .full                (full),
    .empty               (empty),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [EW-1:0] mk(input logic ovf, input int rank, input int cos,
                                       input int grank, input int addr);
    return {1'b0, ovf, 17'(rank), 3'(cos), 6'(grank), 12'(addr)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [EW-1:0] elems [4];
    logic [EW-1:0] h1;
    logic [EW-1:0] h2;
    logic [EW-1:0] hf;
    int ranks [4];
    ranks = '{9, 3, 7, 5};
    for (int i = 0; i < 4; i++) elems[i] = mk(1'b0, ranks[i], i, 2 * i, 16'h100 + i);
    h1 = mk(1'b1, 3, 5, 33, 12'hABC);
    h2 = mk(1'b0, 5, 2, 17, 12'h123);
    hf = mk(1'b1, 7, 1, 9, 12'h055);

    rst = 1'b1; enq_valid = 1'b0; enq_data = '0; deq_req = 1'b0; flush = 1'b0;
    head_element = '0;
    #12;
    chk("rst_enq_ready", enq_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_deq_valid", deq_valid, 0);
    chk("rst_ctl_insert", ctl_insert, 0);
    chk("rst_ctl_pop", ctl_pop, 0);
    chk("rst_gob", global_overflow_bit, 0);
    rst = 1'b0;
    tick();

    // Fill to DEPTH
    for (int i = 0; i < 4; i++) begin
      enq_valid = 1'b1; enq_data = elems[i];
      #1 chk("fill_enq_ready", enq_ready, 1);
      tick();
      chk("fill_ctl_insert", ctl_insert, 1);
      chk("fill_ctl_input", ctl_input, {1'b1, elems[i][38:0]});
      chk("fill_count", count, i + 1);
    end
    enq_valid = 1'b0;
    tick();
    chk("full_ctl_insert", ctl_insert, 0);
    chk("full_count", count, 4);
    chk("full_flag", full, 1);
    chk("full_enq_ready", enq_ready, 0);
    enq_valid = 1'b1; enq_data = mk(1'b0, 1, 0, 0, 12'h200);
    tick();
    chk("full_blocked_insert", ctl_insert, 0);
    chk("full_blocked_count", count, 4);

    // Simultaneous enq+deq at full, head has overflow set
    deq_req = 1'b1; head_element = h1;
    #1 chk("simul_enq_ready", enq_ready, 1);
    tick();
    enq_valid = 1'b0; deq_req = 1'b0;
    chk("simul_insert", ctl_insert, 1);
    chk("simul_pop", ctl_pop, 1);
    chk("simul_count", count, 4);
    chk("simul_no_early_valid", deq_valid, 0);
    tick();
    chk("simul_deq_valid", deq_valid, 1);
    chk("simul_deq_data", deq_data, h1);
    chk("simul_gob", global_overflow_bit, 1);
    chk("simul_pop_done", ctl_pop, 0);

    // Pop with overflow clear
    head_element = h2; deq_req = 1'b1;
    tick();
    deq_req = 1'b0;
    chk("pop2_count", count, 3);
    chk("pop2_deq_valid_low", deq_valid, 0);
    tick();
    chk("pop2_deq_valid", deq_valid, 1);
    chk("pop2_deq_data", deq_data, h2);
    chk("pop2_gob", global_overflow_bit, 0);
    tick();
    chk("pop2_pulse_end", deq_valid, 0);

    // Flush with count=3; enq/deq requests held to show they are ignored
    head_element = hf; flush = 1'b1;
    tick();
    flush = 1'b0; enq_valid = 1'b1; deq_req = 1'b1;
    chk("flush_busy", busy, 1);
    chk("flush_count", count, 3);
    #1 chk("flush_enq_ready", enq_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush_ctl_pop", ctl_pop, 1);
      chk("flush_ctl_insert", ctl_insert, 0);
      chk("flush_count_dec", count, 2 - k);
      chk("flush_no_deq_valid", deq_valid, 0);
    end
    enq_valid = 1'b0; deq_req = 1'b0;
    tick();
    chk("flush_tail_pop", ctl_pop, 0);
    chk("flush_tail_deq_valid", deq_valid, 0);
    chk("flush_tail_busy", busy, 1);
    chk("flush_gob", global_overflow_bit, 1);
    tick();
    chk("flush_exit_busy", busy, 0);
    chk("flush_exit_empty", empty, 1);
    chk("flush_exit_count", count, 0);

    // deq_req while empty
    deq_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("empty_deq_pop", ctl_pop, 0);
      chk("empty_deq_valid", deq_valid, 0);
      chk("empty_deq_count", count, 0);
    end
    enq_valid = 1'b1; enq_data = elems[0];
    tick();
    enq_valid = 1'b0; deq_req = 1'b0;
    chk("empty_both_insert", ctl_insert, 1);
    chk("empty_both_pop", ctl_pop, 0);
    chk("empty_both_count", count, 1);

    // Reset with count=2 and a pop in flight
    enq_valid = 1'b1;
    tick();
    tick();
    enq_valid = 1'b0;
    chk("pre_rst_count3", count, 3);
    deq_req = 1'b1;
    tick();
    deq_req = 1'b0;
    chk("pre_rst_pop", ctl_pop, 1);
    chk("pre_rst_count2", count, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_full", full, 0);
    chk("arst_ctl_pop", ctl_pop, 0);
    chk("arst_ctl_insert", ctl_insert, 0);
    chk("arst_ctl_input", ctl_input, 0);
    chk("arst_deq_valid", deq_valid, 0);
    chk("arst_deq_data", deq_data, 0);
    chk("arst_gob", global_overflow_bit, 0);
    chk("arst_busy", busy, 0);
    chk("arst_enq_ready", enq_ready, 0);
    tick();
    chk("arst_hold_deq_valid", deq_valid, 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_deq_valid", deq_valid, 0);
      chk("post_rst_count", count, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
